lzc_pipe: RTL and testbench



---
 rtl/posit_pkg.sv | 27 ++
 rtl/lzc_pipe_if.sv | 57 +++++
 rtl/lzc_merge.sv | 22 ++
 rtl/lzc_pipe.sv | 151 +++++++++++++++
 tb/tb_lzc_pipe.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/posit_pkg.sv
// Shared constants and elaboration-time helpers for the posit decoder
// building blocks. The leading-count pipeline uses the mode encoding and
// the tree-depth / stage-count helpers below.
package posit_pkg;

   // Count mode: which bit value is being counted from the MSB down.
   localparam logic LZC_MODE_ZERO = 1'b0;
   localparam logic LZC_MODE_ONE  = 1'b1;

   // Ceiling log2, usable in parameter and localparam expressions.
   // clog2(1) = 0, clog2(2) = 1, clog2(16) = 4.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Number of pipeline stages for a tree of depth s when a register is
   // placed after every re merge levels (and always after the last one).
   function automatic int lzc_stages(input int s, input int re);
      return (s + re - 1) / re;
   endfunction

endpackage

// File: rtl/lzc_pipe_if.sv
// Bundle of the upstream and downstream handshake signals of lzc_pipe.
//
// Handshake: both sides use strict valid/ready. A transfer happens on a
// rising clock edge where valid and ready are both high. A source that has
// raised valid keeps it (and its payload) stable until the transfer; ready
// may depend combinationally on downstream ready, never on valid of the
// same side. in_data is don't-care while in_valid is low.
//
// master: the environment (drives inputs, consumes results).
// slave : the counter pipeline.
interface lzc_pipe_if #(
   parameter int N     = 16,
   parameter int TAG_W = 4
);
   import posit_pkg::*;

   localparam int S = clog2(N);

   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_data;
   logic             in_mode;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [S:0]       out_count;
   logic             out_all;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid,
      output in_data,
      output in_mode,
      output in_tag,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_count,
      input  out_all,
      input  out_tag
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_mode,
      input  in_tag,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_count,
      output out_all,
      output out_tag
   );

endinterface

// File: rtl/lzc_merge.sv
// One merge node of the leading-zero tree. Combines the node covering the
// upper half (h) with the node covering the lower half (l). When the upper
// half is entirely zero the count continues into the lower half, which is
// expressed by setting the new MSB and taking the lower count verbatim.
module lzc_merge #(
   parameter int W = 1
) (
   input  logic         h_all,
   input  logic [W-1:0] h_cnt,
   input  logic         l_all,
   input  logic [W-1:0] l_cnt,
   output logic         all,
   output logic [W:0]   cnt
);

   // Both halves zero means the merged span is zero.
   assign all = h_all & l_all;

   // Upper half all-zero: count = half width + lower count; else upper count.
   assign cnt = h_all ? {1'b1, l_cnt} : {1'b0, h_cnt};

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined leading-zero / leading-one counter.
//
// The input is optionally inverted at the front end so the tree always
// counts leading zeros. The tree has S = log2(N) levels; level 1 works on
// bit pairs, every higher level merges node pairs with lzc_merge. A stage
// register follows every REG_EVERY levels and always the last level, so
// there are P = ceil(S / REG_EVERY) stages and the outputs are registered.
//
// Flow control is a stall-propagating chain: a stage loads when it is empty
// or when its successor loads this cycle, so bubbles collapse and a full
// pipeline still accepts one item per cycle while the output drains.
module lzc_pipe
   import posit_pkg::*;
#(
   parameter int N         = 16,
   parameter int REG_EVERY = 1,
   parameter int TAG_W     = 4
) (
   input logic         clk,
   input logic         rst_n,
   lzc_pipe_if.slave   bus
);

   localparam int S  = clog2(N);
   localparam int P  = lzc_stages(S, REG_EVERY);
   localparam int CW = S + 1;

   // Front-end value: leading ones become leading zeros.
   logic [N-1:0]     x;

   // Per-stage control and sideband.
   logic [P-1:0]     valid_q;
   logic [P-1:0]     valid_chain;
   logic [P-1:0]     rdy_v;
   logic             rdy_acc;
   logic [TAG_W-1:0] tag_q       [P];
   logic [TAG_W-1:0] tag_chain   [P];

   // Root node of the tree after the last stage register.
   logic             all_f;
   logic [S-1:0]     cnt_f;

   assign x = (bus.in_mode == LZC_MODE_ONE) ? ~bus.in_data : bus.in_data;

   // Ready chain from the output back to the input: stage k may load when
   // it is empty or when everything behind it can move on.
   always_comb begin
      rdy_v   = '0;
      rdy_acc = bus.out_ready;
      for (int k = P - 1; k >= 0; k--) begin
         rdy_acc  = ~valid_q[k] | rdy_acc;
         rdy_v[k] = rdy_acc;
      end
   end

   // What each stage would load: the front end for stage 0, else its predecessor.
   for (genvar k = 0; k < P; k++) begin : g_chain
      if (k == 0) begin : g_first
         assign valid_chain[k] = bus.in_valid;
         assign tag_chain[k]   = bus.in_tag;
      end else begin : g_next
         assign valid_chain[k] = valid_q[k-1];
         assign tag_chain[k]   = tag_q[k-1];
      end
   end

   // Stage valid and tag registers advance together whenever the stage is ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int k = 0; k < P; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < P; k++) begin
            if (rdy_v[k]) begin
               valid_q[k] <= valid_chain[k];
               tag_q[k]   <= tag_chain[k];
            end
         end
      end
   end

   // Tree levels. Level lv has N >> lv nodes, each with an lv-bit count.
   // Node i of a level covers input bits [(i+1)*2^lv - 1 : i*2^lv]; the
   // higher node index is the more significant half.
   for (genvar lv = 1; lv <= S; lv++) begin : g_lvl
      localparam int M      = N >> lv;
      localparam int W      = lv;
      localparam int STG    = (lv - 1) / REG_EVERY;
      localparam bit IS_REG = ((lv % REG_EVERY) == 0) || (lv == S);

      logic [M-1:0]   all_c;
      logic [M-1:0]   all_o;
      logic [M*W-1:0] cnt_c;
      logic [M*W-1:0] cnt_o;

      if (lv == 1) begin : g_leaf
         // Bit pair (hi, lo): zero-pair flag, and a count of 1 for "01".
         for (genvar i = 0; i < M; i++) begin : g_node
            assign all_c[i] = ~x[2*i+1] & ~x[2*i];
            assign cnt_c[i] = ~x[2*i+1] &  x[2*i];
         end
      end else begin : g_tree
         for (genvar i = 0; i < M; i++) begin : g_node
            lzc_merge #(
               .W (W - 1)
            ) u_merge (
               .h_all (g_lvl[lv-1].all_o[2*i+1]),
               .h_cnt (g_lvl[lv-1].cnt_o[(2*i+1)*(W-1) +: (W-1)]),
               .l_all (g_lvl[lv-1].all_o[2*i]),
               .l_cnt (g_lvl[lv-1].cnt_o[(2*i)*(W-1) +: (W-1)]),
               .all   (all_c[i]),
               .cnt   (cnt_c[i*W +: W])
            );
         end
      end

      if (IS_REG) begin : g_reg
         logic [M-1:0]   all_q;
         logic [M*W-1:0] cnt_q;

         // Closes pipeline stage STG; holds while that stage is stalled.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               all_q <= '0;
               cnt_q <= '0;
            end else if (rdy_v[STG]) begin
               all_q <= all_c;
               cnt_q <= cnt_c;
            end
         end

         assign all_o = all_q;
         assign cnt_o = cnt_q;
      end else begin : g_comb
         assign all_o = all_c;
         assign cnt_o = cnt_c;
      end
   end

   assign all_f = g_lvl[S].all_o[0];
   assign cnt_f = g_lvl[S].cnt_o;

   assign bus.in_ready  = rdy_v[0];
   assign bus.out_valid = valid_q[P-1];
   assign bus.out_all   = all_f;
   assign bus.out_count = all_f ? CW'(N) : {1'b0, cnt_f};
   assign bus.out_tag   = tag_q[P-1];

endmodule

// File: tb/tb_lzc_pipe.sv
// Bench for lzc_pipe: three instances (N=16/RE=1, N=2/RE=1, N=32/RE=2)
// sharing clock and reset. A per-cycle monitor keeps an expected queue per
// instance filled from a plain bit-scan reference model at every input
// handshake and checks every output handshake and every output stall.
module tb_lzc_pipe;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;

   initial forever #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- counters ----------------
   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- DUTs ----------------
   lzc_pipe_if #(.N(16), .TAG_W(4)) if16 ();
   lzc_pipe_if #(.N(2),  .TAG_W(4)) if2  ();
   lzc_pipe_if #(.N(32), .TAG_W(4)) if32 ();

   lzc_pipe #(.N(16), .REG_EVERY(1), .TAG_W(4)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if16)
   );

   lzc_pipe #(.N(2), .REG_EVERY(1), .TAG_W(4)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if2)
   );

   lzc_pipe #(.N(32), .REG_EVERY(2), .TAG_W(4)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if32)
   );

   // ---------------- scoreboard state ----------------
   // Entry format: {count[7:0], all, tag[3:0]}
   logic [12:0] exp_q16[$];
   logic [12:0] exp_q2[$];
   logic [12:0] exp_q32[$];
   logic        held     [3];
   logic [12:0] held_val [3];

   // ---------------- reference model ----------------
   // Scan from the MSB of an n-bit value, counting bits equal to the mode.
   function automatic logic [12:0] ref_pack(input logic [31:0] d, input logic m,
                                            input int n, input logic [3:0] t);
      int c;
      bit run;
      c   = 0;
      run = 1'b1;
      for (int b = n - 1; b >= 0; b--) begin
         if (run && (d[b] == m)) c++;
         else run = 1'b0;
      end
      return {8'(c), (c == n), t};
   endfunction

   // ---------------- instance access helpers ----------------
   function automatic int nw(input int w);
      case (w)
         0:       return 16;
         1:       return 2;
         default: return 32;
      endcase
   endfunction

   function automatic logic [31:0] mask_of(input int w);
      case (w)
         0:       return 32'h0000_FFFF;
         1:       return 32'h0000_0003;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic logic in_v(input int w);
      case (w)
         0:       return if16.in_valid;
         1:       return if2.in_valid;
         default: return if32.in_valid;
      endcase
   endfunction

   function automatic logic in_rdy(input int w);
      case (w)
         0:       return if16.in_ready;
         1:       return if2.in_ready;
         default: return if32.in_ready;
      endcase
   endfunction

   function automatic logic [31:0] in_d(input int w);
      case (w)
         0:       return {16'h0, if16.in_data};
         1:       return {30'h0, if2.in_data};
         default: return if32.in_data;
      endcase
   endfunction

   function automatic logic in_m(input int w);
      case (w)
         0:       return if16.in_mode;
         1:       return if2.in_mode;
         default: return if32.in_mode;
      endcase
   endfunction

   function automatic logic [3:0] in_t(input int w);
      case (w)
         0:       return if16.in_tag;
         1:       return if2.in_tag;
         default: return if32.in_tag;
      endcase
   endfunction

   function automatic logic out_v(input int w);
      case (w)
         0:       return if16.out_valid;
         1:       return if2.out_valid;
         default: return if32.out_valid;
      endcase
   endfunction

   function automatic logic out_rdy(input int w);
      case (w)
         0:       return if16.out_ready;
         1:       return if2.out_ready;
         default: return if32.out_ready;
      endcase
   endfunction

   function automatic logic [12:0] obs(input int w);
      case (w)
         0:       return {8'(if16.out_count), if16.out_all, if16.out_tag};
         1:       return {8'(if2.out_count),  if2.out_all,  if2.out_tag};
         default: return {8'(if32.out_count), if32.out_all, if32.out_tag};
      endcase
   endfunction

   function automatic int qsize(input int w);
      case (w)
         0:       return exp_q16.size();
         1:       return exp_q2.size();
         default: return exp_q32.size();
      endcase
   endfunction

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input int w, input logic v, input logic [31:0] d,
                        input logic m, input logic [3:0] t);
      case (w)
         0: begin
            if16.in_valid = v; if16.in_data = d[15:0]; if16.in_mode = m; if16.in_tag = t;
         end
         1: begin
            if2.in_valid = v;  if2.in_data = d[1:0];   if2.in_mode = m;  if2.in_tag = t;
         end
         default: begin
            if32.in_valid = v; if32.in_data = d;       if32.in_mode = m; if32.in_tag = t;
         end
      endcase
   endtask

   task automatic set_oready(input int w, input logic r);
      case (w)
         0:       if16.out_ready = r;
         1:       if2.out_ready  = r;
         default: if32.out_ready = r;
      endcase
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         for (int w = 0; w < 3; w++) begin
            drive(w, 1'b0, 32'h0, 1'b0, 4'h0);
            set_oready(w, 1'b1);
         end
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic mon(input int w);
      logic [12:0] o;
      logic [12:0] e;
      int          sz;
      if (!rst_n) begin
         case (w)
            0:       exp_q16.delete();
            1:       exp_q2.delete();
            default: exp_q32.delete();
         endcase
         held[w] = 1'b0;
         return;
      end
      o = obs(w);
      if (held[w]) begin
         chk($sformatf("hold_valid_n%0d", nw(w)), 32'(out_v(w)), 32'd1);
         chk($sformatf("hold_data_n%0d", nw(w)), 32'(o), 32'(held_val[w]));
      end
      if (out_v(w) && out_rdy(w)) begin
         sz = qsize(w);
         chk($sformatf("out_expected_n%0d", nw(w)), 32'(sz > 0), 32'd1);
         if (sz > 0) begin
            case (w)
               0:       e = exp_q16.pop_front();
               1:       e = exp_q2.pop_front();
               default: e = exp_q32.pop_front();
            endcase
            chk($sformatf("scoreboard_n%0d", nw(w)), 32'(o), 32'(e));
         end
      end
      if (in_v(w) && in_rdy(w)) begin
         e = ref_pack(in_d(w), in_m(w), nw(w), in_t(w));
         case (w)
            0:       exp_q16.push_back(e);
            1:       exp_q2.push_back(e);
            default: exp_q32.push_back(e);
         endcase
      end
      held[w]     = out_v(w) & ~out_rdy(w);
      held_val[w] = o;
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
      mon(2);
   end

   // ---------------- directed single-item latency check ----------------
   task automatic lat_check(input int w, input logic [31:0] d, input logic m,
                            input logic [3:0] t, input int exp_lat,
                            input int exp_cnt, input logic exp_all);
      bit          got;
      int          lat;
      logic [12:0] o;
      @(posedge clk);
      #1;
      set_oready(w, 1'b1);
      drive(w, 1'b1, d, m, t);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (in_rdy(w)) got = 1'b1;
         @(posedge clk);
      end
      #1;
      drive(w, 1'b0, 32'h0, 1'b0, 4'h0);
      chk($sformatf("lat_accept_n%0d", nw(w)), 32'(got), 32'd1);
      lat = 1;
      while (!out_v(w) && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      o = obs(w);
      chk($sformatf("latency_n%0d", nw(w)), lat, exp_lat);
      chk($sformatf("count_n%0d_%0h", nw(w), d), 32'(o[12:5]), exp_cnt);
      chk($sformatf("all_n%0d_%0h", nw(w), d), 32'(o[4]), 32'(exp_all));
      chk($sformatf("tag_n%0d", nw(w)), 32'(o[3:0]), 32'(t));
   endtask

   // ---------------- back-pressure burst on the N=16 instance ----------------
   task automatic backpressure();
      logic [31:0] bd [8];
      logic        bm [8];
      int          item, occ, nexp;
      logic        oready, acc, emt;
      logic [12:0] o;
      for (int i = 0; i < 8; i++) begin
         bd[i] = 32'($urandom_range(0, 65535));
         bm[i] = 1'($urandom_range(0, 1));
      end
      item = 0;
      occ  = 0;
      nexp = 0;
      for (int c = 0; c < 60 && nexp < 8; c++) begin
         @(posedge clk);
         #1;
         oready = !(c >= 3 && c <= 8);
         set_oready(0, oready);
         if (item < 8) drive(0, 1'b1, bd[item], bm[item], 4'(item));
         else          drive(0, 1'b0, 32'h0, 1'b0, 4'h0);
         @(negedge clk);
         chk("bp_in_ready", 32'(in_rdy(0)), 32'((occ < 4) || oready));
         acc = in_v(0) && in_rdy(0);
         emt = out_v(0) && oready;
         if (emt) begin
            o = obs(0);
            chk("bp_tag_order", 32'(o[3:0]), nexp);
            nexp++;
            occ--;
         end
         if (acc) begin
            item++;
            occ++;
         end
      end
      chk("bp_all_out", nexp, 8);
   endtask

   // ---------------- reset with items in flight ----------------
   task automatic reset_midstream();
      bit          seen;
      logic [12:0] o;
      set_oready(0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         drive(0, 1'b1, 32'($urandom_range(0, 65535)), 1'b0, 4'(i + 1));
      end
      @(posedge clk);
      #1;
      drive(0, 1'b0, 32'h0, 1'b0, 4'h0);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         if (out_v(0)) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("pre_rst_valid", 32'(seen), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      o = obs(0);
      chk("rst_async_valid", 32'(out_v(0)), 32'd0);
      chk("rst_async_outputs", 32'(o), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      set_oready(0, 1'b1);
      @(posedge clk);
      #1;
      chk("rst_rel_ready", 32'(in_rdy(0)), 32'd1);
      for (int c = 0; c < 8; c++) begin
         chk("no_stale_out", 32'(out_v(0)), 32'd0);
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- random traffic with random back-pressure ----------------
   task automatic rnd(input int w, input int ncyc);
      logic        v, m;
      logic [31:0] d;
      int          sh;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         v  = ($urandom_range(0, 3) != 0);
         m  = 1'($urandom_range(0, 1));
         sh = $urandom_range(0, nw(w));
         d  = $urandom & mask_of(w);
         d  = (sh >= 32) ? 32'h0 : (d >> sh);
         if (m) d = ~d & mask_of(w);
         drive(w, v, d, m, 4'($urandom_range(0, 15)));
         set_oready(w, ($urandom_range(0, 2) != 0));
      end
      @(posedge clk);
      #1;
      drive(w, 1'b0, 32'h0, 1'b0, 4'h0);
      set_oready(w, 1'b1);
      for (int i = 0; i < 50 && qsize(w) != 0; i++) @(negedge clk);
      chk($sformatf("drain_empty_n%0d", nw(w)), qsize(w), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [12:0] o;
      rst_n = 1'b0;
      for (int w = 0; w < 3; w++) begin
         drive(w, 1'b0, 32'h0, 1'b0, 4'h0);
         set_oready(w, 1'b1);
      end
      repeat (3) @(posedge clk);
      #1;
      o = obs(0);
      chk("rst_out_valid_n16", 32'(if16.out_valid), 32'd0);
      chk("rst_outputs_n16", 32'(o), 32'd0);
      chk("rst_out_valid_n2", 32'(if2.out_valid), 32'd0);
      chk("rst_out_valid_n32", 32'(if32.out_valid), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int w = 0; w < 3; w++) chk($sformatf("rdy_after_rst_n%0d", nw(w)), 32'(in_rdy(w)), 32'd1);

      lat_check(0, 32'h0000_0001, 1'b0, 4'h1, 4, 15, 1'b0);
      lat_check(0, 32'h0000_0000, 1'b0, 4'h2, 4, 16, 1'b1);
      lat_check(0, 32'h0000_FFFF, 1'b0, 4'h4, 4, 0,  1'b0);
      lat_check(0, 32'h0000_FFFF, 1'b1, 4'h5, 4, 16, 1'b1);
      lat_check(0, 32'h0000_F0FF, 1'b1, 4'h3, 4, 4,  1'b0);
      lat_check(0, 32'h0000_00F0, 1'b0, 4'h9, 4, 8,  1'b0);
      lat_check(1, 32'h0000_0001, 1'b0, 4'h5, 1, 1,  1'b0);
      lat_check(1, 32'h0000_0000, 1'b0, 4'h6, 1, 2,  1'b1);
      lat_check(1, 32'h0000_0003, 1'b1, 4'h7, 1, 2,  1'b1);
      lat_check(1, 32'h0000_0002, 1'b1, 4'h8, 1, 1,  1'b0);
      lat_check(2, 32'h0000_8000, 1'b0, 4'hA, 3, 16, 1'b0);
      lat_check(2, 32'hFFFF_FFFF, 1'b1, 4'hB, 3, 32, 1'b1);
      lat_check(2, 32'h0000_0000, 1'b1, 4'hC, 3, 0,  1'b0);
      idle(6);

      backpressure();
      idle(6);

      reset_midstream();
      idle(2);

      rnd(0, 10000);
      rnd(1, 2000);
      rnd(2, 3000);
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
